pixel_fetcher: RTL and testbench

Sits downstream of the pixel decoder and serves as the SRAM-read side of the frame pipeline. It accepts one (object id, object pixel index) request per cycle and turns it into an SRAM word address using a per-object base. It issues the read, realigns the returned RGB565 word across a fixed read latency, and delivers RGB888 pixels through a small show-ahead FIFO with valid/ready backpressure toward the VGA output stage.

---
 rtl/pixel_fetcher.sv | 168 ++++++++++++++++
 tb/tb_pixel_fetcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetcher.sv
// SRAM read side of the frame pipeline: maps (object, index) requests to word
// addresses, tracks reads across a fixed latency and queues RGB888 pixels.
package sram_pkg;
  localparam int MAP_H_WIDTH = 10;
  localparam int MAP_V_WIDTH = 9;
endpackage

package object_pkg;
  typedef enum logic [1:0] {
    OBJECT_MAP  = 2'd0,
    OBJECT_CAR1 = 2'd1,
    OBJECT_CAR2 = 2'd2,
    OBJECT_BAR  = 2'd3
  } ObjectID;
endpackage

module pixel_fetcher #(
  parameter int ADDR_WIDTH = 20,
  parameter int IDX_WIDTH  = sram_pkg::MAP_H_WIDTH + sram_pkg::MAP_V_WIDTH,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] MAP_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] CAR1_BASE = ADDR_WIDTH'('h60000),
  parameter logic [ADDR_WIDTH-1:0] CAR2_BASE = ADDR_WIDTH'('h61000),
  parameter logic [ADDR_WIDTH-1:0] BAR_BASE  = ADDR_WIDTH'('h62000)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  object_pkg::ObjectID   i_object_id,
  input  logic [IDX_WIDTH-1:0]  i_pixel_index,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_rd_n,
  input  logic [15:0]           i_sram_rdata,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic [7:0]            o_pix_r,
  output logic [7:0]            o_pix_g,
  output logic [7:0]            o_pix_b,
  output object_pkg::ObjectID   o_pix_object,
  output logic                  o_addr_overflow
);
  import object_pkg::*;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    ObjectID    obj;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   sum;
  logic                  accept, push, pop;
  logic [CNT_W:0]        infl_cnt, credit_used;
  pix_t                  push_pix, head_pix;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_n_q, rd_n_d;
  logic                  ovf_q, ovf_d;
  logic [RD_LAT-1:0]     infl_v_q, infl_v_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  ObjectID               infl_tag_q [RD_LAT];
  pix_t                  fifo_mem_q [FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: the default arm gives every id a value, so this stays purely combinational (no latch).
  always_comb begin
    case (i_object_id)
      OBJECT_CAR1: base = CAR1_BASE;
      OBJECT_CAR2: base = CAR2_BASE;
      OBJECT_BAR:  base = BAR_BASE;
      default:     base = MAP_BASE;
    endcase
  end

  assign sum = {1'b0, base} + {{(ADDR_WIDTH + 1 - IDX_WIDTH){1'b0}}, i_pixel_index};

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + (CNT_W+1)'(infl_v_q[i]);
  end

  // Credits cover both queued and in-flight pixels, so a push never meets a full FIFO.
  assign credit_used = (CNT_W+1)'(count_q) + infl_cnt;
  assign o_req_ready = i_rst_n && !i_flush && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign accept      = i_req_valid && o_req_ready;
  assign o_pix_valid = (count_q != '0);
  assign push        = infl_v_q[RD_LAT-1] && !i_flush;
  assign pop         = o_pix_valid && i_pix_ready && !i_flush;

  always_comb begin
    push_pix.obj = infl_tag_q[RD_LAT-1];
    push_pix.r   = {i_sram_rdata[15:11], i_sram_rdata[15:13]};
    push_pix.g   = {i_sram_rdata[10:5],  i_sram_rdata[10:9]};
    push_pix.b   = {i_sram_rdata[4:0],   i_sram_rdata[4:2]};
  end

  always_comb begin
    addr_d   = accept ? sum[ADDR_WIDTH-1:0] : addr_q;
    rd_n_d   = !accept;
    ovf_d    = ovf_q | (accept & sum[ADDR_WIDTH]);
    infl_v_d = i_flush ? '0 : ((infl_v_q << 1) | RD_LAT'(accept));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      rd_n_q   <= 1'b1;
      ovf_q    <= 1'b0;
      infl_v_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      rd_n_q   <= rd_n_d;
      ovf_q    <= ovf_d;
      infl_v_q <= infl_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; validity lives in the reset counters and the outputs are masked while empty.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_pix;
    infl_tag_q[0] <= i_object_id;
    for (int i = 1; i < RD_LAT; i++) infl_tag_q[i] <= infl_tag_q[i-1];
  end

  assign head_pix        = fifo_mem_q[rd_ptr_q];
  assign o_pix_r         = o_pix_valid ? head_pix.r : '0;
  assign o_pix_g         = o_pix_valid ? head_pix.g : '0;
  assign o_pix_b         = o_pix_valid ? head_pix.b : '0;
  assign o_pix_object    = o_pix_valid ? head_pix.obj : OBJECT_MAP;
  assign o_sram_addr     = addr_q;
  assign o_sram_rd_n     = rd_n_q;
  assign o_addr_overflow = ovf_q;

endmodule

// File: tb/tb_pixel_fetcher.sv
// Scoreboard bench for pixel_fetcher: addresses, colour expansion, latency,
// backpressure, flush, overflow and asynchronous reset.
module tb_pixel_fetcher;
  import object_pkg::*;

  localparam int IW = 19;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            pix_ready = 1'b0;
  ObjectID         obj_id = OBJECT_MAP;
  logic [IW-1:0]   pix_idx = '0;
  logic [15:0]     sram_rdata = 16'h0;
  logic            o_req_ready, o_sram_rd_n, o_pix_valid, o_addr_overflow;
  logic [19:0]     o_sram_addr;
  logic [7:0]      o_pix_r, o_pix_g, o_pix_b;
  ObjectID         o_pix_object;

  int total = 0;
  int bad = 0;

  pixel_fetcher #(.BAR_BASE(20'hFFFFE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_object_id(obj_id), .i_pixel_index(pix_idx),
    .o_sram_addr(o_sram_addr), .o_sram_rd_n(o_sram_rd_n), .i_sram_rdata(sram_rdata),
    .o_pix_valid(o_pix_valid), .i_pix_ready(pix_ready),
    .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b),
    .o_pix_object(o_pix_object), .o_addr_overflow(o_addr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // SRAM contents: a few fixed words, everything else a hash of the address.
  logic [15:0] mem [logic [19:0]];

  function automatic logic [15:0] sram_word(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [19:0] model_addr(input ObjectID id, input logic [IW-1:0] idx);
    logic [19:0] b;
    logic [20:0] s;
    case (id)
      OBJECT_CAR1: b = 20'h60000;
      OBJECT_CAR2: b = 20'h61000;
      OBJECT_BAR:  b = 20'hFFFFE;
      default:     b = 20'h00000;
    endcase
    s = {1'b0, b} + {2'b00, idx};
    return s[19:0];
  endfunction

  function automatic logic [25:0] model_pix(input ObjectID id, input logic [15:0] w);
    return {id, w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  // Read data valid RD_LAT=2 edges after the accepting edge.
  always @(posedge clk) sram_rdata <= !o_sram_rd_n ? sram_word(o_sram_addr) : 16'h0BAD;

  logic        pend_addr = 1'b0;
  logic [19:0] exp_addr = '0;
  logic [25:0] last_pix = '0;
  logic [25:0] exp_pix;
  logic [25:0] sb [$];
  int          acc_cnt = 0;
  int          pop_cnt = 0;

  // Monitor at negedge: inputs and outputs are stable and predict the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_addr = 1'b0;
    end else begin
      if (pend_addr) begin
        check("sram_addr", 32'(o_sram_addr), 32'(exp_addr));
        check("rd_n_active", 32'(o_sram_rd_n), 32'd0);
      end else begin
        check("rd_n_idle", 32'(o_sram_rd_n), 32'd1);
      end
      if (flush) check("ready_in_flush", 32'(o_req_ready), 32'd0);
      pend_addr = req_valid && o_req_ready;
      if (pend_addr) begin
        exp_addr = model_addr(obj_id, pix_idx);
        sb.push_back(model_pix(obj_id, sram_word(exp_addr)));
        acc_cnt++;
      end
      if (flush) begin
        sb.delete();
      end else if (o_pix_valid && pix_ready) begin
        pop_cnt++;
        last_pix = {o_pix_object, o_pix_r, o_pix_g, o_pix_b};
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_pix = sb.pop_front();
          check("pixel", 32'(last_pix), 32'(exp_pix));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_rd_n", 32'(o_sram_rd_n), 32'd1);
    check("rst_addr", 32'(o_sram_addr), 32'd0);
    check("rst_pix_valid", 32'(o_pix_valid), 32'd0);
    check("rst_r", 32'(o_pix_r), 32'd0);
    check("rst_g", 32'(o_pix_g), 32'd0);
    check("rst_b", 32'(o_pix_b), 32'd0);
    check("rst_obj", 32'(o_pix_object), 32'(OBJECT_MAP));
    check("rst_ovf", 32'(o_addr_overflow), 32'd0);
  endtask

  task automatic single_req(input ObjectID id, input logic [IW-1:0] idx,
                            input logic [19:0] exp_a, input string tag);
    req_valid = 1'b1;
    obj_id    = id;
    pix_idx   = idx;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check(tag, 32'(o_sram_addr), 32'(exp_a));
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    req_valid = 1'b0;
    pix_ready = 1'b1;
    while ((sb.size() != 0 || o_pix_valid) && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(sb.size()) + 32'(o_pix_valid), 32'd0);
  endtask

  int a0, p0;

  initial begin
    mem[20'h61005] = 16'hF800;
    mem[20'h61006] = 16'h07E0;
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    tick();
    rst_n     = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(o_req_ready), 32'd1);

    // Back-to-back MAP requests 0,1,2: pixels stream RD_LAT edges later, no bubbles.
    tick();
    a0 = acc_cnt;
    req_valid = 1'b1;
    obj_id    = OBJECT_MAP;
    pix_idx   = 0;
    tick();
    pix_idx = 1;
    @(negedge clk);
    check("b2b_pv_k0", 32'(o_pix_valid), 32'd0);
    tick();
    pix_idx = 2;
    @(negedge clk);
    check("b2b_pv_k1", 32'(o_pix_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_pv_stream", 32'(o_pix_valid), 32'd1);
      tick();
    end
    @(negedge clk);
    check("b2b_pv_end", 32'(o_pix_valid), 32'd0);
    check("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
    tick();

    // Base address and colour expansion.
    single_req(OBJECT_CAR2, 5, 20'h61005, "car2_addr");
    drain("car2_drain");
    check("car2_rgb", 32'(last_pix[23:0]), 32'hFF0000);
    check("car2_tag", 32'(last_pix[25:24]), 32'(OBJECT_CAR2));
    single_req(OBJECT_CAR2, 6, 20'h61006, "green_addr");
    drain("green_drain");
    check("green_rgb", 32'(last_pix[23:0]), 32'h00FF00);

    // Backpressure: FIFO_DEPTH credits, then one accept per pop.
    pix_ready = 1'b0;
    req_valid = 1'b1;
    obj_id    = OBJECT_CAR1;
    a0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      pix_idx = IW'(200 + i);
      tick();
    end
    check("bp_fill_accepts", 32'(acc_cnt - a0), 32'd4);
    check("bp_ready_low", 32'(o_req_ready), 32'd0);
    check("bp_pv_full", 32'(o_pix_valid), 32'd1);
    pix_ready = 1'b1;
    a0 = acc_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      pix_idx = IW'(300 + i);
      tick();
    end
    req_valid = 1'b0;
    check("bp_pops", 32'(pop_cnt - p0), 32'd10);
    check("bp_accept_per_pop", 32'(acc_cnt - a0), 32'd9);
    drain("bp_drain");

    // Overflow: BAR base 0xFFFFE + 3 wraps to 1 and the flag sticks.
    check("ovf_clear", 32'(o_addr_overflow), 32'd0);
    single_req(OBJECT_BAR, 3, 20'h00001, "ovf_addr");
    check("ovf_set", 32'(o_addr_overflow), 32'd1);
    single_req(OBJECT_MAP, 7, 20'h00007, "legal_addr");
    check("ovf_held", 32'(o_addr_overflow), 32'd1);
    drain("ovf_drain");

    // Flush with two reads in flight.
    p0 = pop_cnt;
    req_valid = 1'b1;
    obj_id    = OBJECT_CAR1;
    pix_idx   = 10;
    tick();
    pix_idx = 11;
    @(negedge clk);
    check("flush_pv_k0", 32'(o_pix_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_pv_k1", 32'(o_pix_valid), 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_pv_quiet", 32'(o_pix_valid), 32'd0);
      tick();
    end
    check("ovf_after_flush", 32'(o_addr_overflow), 32'd1);
    single_req(OBJECT_MAP, 12, 20'h0000C, "post_flush_addr");
    drain("flush_drain");
    check("flush_pops", 32'(pop_cnt - p0), 32'd1);

    // Asynchronous reset with pixels queued and reads in flight.
    pix_ready = 1'b0;
    req_valid = 1'b1;
    obj_id    = OBJECT_CAR1;
    for (int i = 0; i < 4; i++) begin
      pix_idx = IW'(400 + i);
      tick();
    end
    req_valid = 1'b0;
    check("pre_rst_pv", 32'(o_pix_valid), 32'd1);
    check("pre_rst_rd_n", 32'(o_sram_rd_n), 32'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 check_reset_values();
    @(posedge clk);
    tick();
    rst_n     = 1'b1;
    pix_ready = 1'b1;
    req_valid = 1'b1;
    obj_id    = OBJECT_MAP;
    pix_idx   = 20;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_lat_k0", 32'(o_pix_valid), 32'd0);
    tick();
    @(negedge clk);
    check("rst_lat_k1", 32'(o_pix_valid), 32'd0);
    tick();
    @(negedge clk);
    check("rst_lat_k2", 32'(o_pix_valid), 32'd1);
    tick();
    drain("rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
